sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Command-driven sprite blitter that sits directly upstream of the double-buffered frame-buffer controller.
- Accepts blit commands through a small FIFO: sprite index plus top-left screen position.
- For each command it walks the 32x32 sprite and drives sprite-ROM read addresses, then matching screen write addresses one cycle later.
- The controller combines the ROM data and alpha to write the back buffer.

Parameters:
SCREEN_WIDTH, 320, visible columns
SCREEN_HEIGHT, 180, visible rows
SPRITE_SIZE, 32, sprite edge in pixels (power of two)
SPRITE_IDX_WIDTH, 3, sprite index bits (8 sprites)
VRAM_A_WIDTH, 16, screen address width
SPRITEBUF_A_WIDTH, 15, sprite ROM address width
CMD_FIFO_DEPTH, 4, command FIFO entries (power of two)

Ports:
CLK  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
i_frame_clear  in  1  sync pulse: flush FIFO, abort current blit
i_cmd_valid  in  1  command push request
o_cmd_ready  out  1  FIFO not full
i_cmd_index  in  SPRITE_IDX_WIDTH  sprite number
i_cmd_x  in  10  sprite left column, unsigned
i_cmd_y  in  10  sprite top row, unsigned
o_address_s  out  SPRITEBUF_A_WIDTH  sprite ROM read address
o_address_screen  out  VRAM_A_WIDTH  frame-buffer write address
o_is_layer_drawing  out  1  o_address_screen valid for a visible pixel this cycle
o_busy  out  1  blit in progress or FIFO non-empty
o_blit_done  out  1  one-cycle pulse when a blit's last pixel has been emitted

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty; FSM IDLE.
  - All outputs 0, except o_cmd_ready=1.
- Push:
  - A command is accepted when i_cmd_valid && o_cmd_ready on a clock edge.
  - o_cmd_ready = !full, registered-count based. There is no same-cycle bypass; a pop in the same cycle does not raise ready.
- FSM states IDLE, LOAD, RUN, DRAIN:
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD (1 cycle): pop the head; latch index/x/y; clear row/col to 0; go to RUN.
  - RUN (SPRITE_SIZE^2 cycles):
    - Each cycle, o_address_s = index*SPRITE_SIZE^2 + row*SPRITE_SIZE + col.
    - col increments; on wrap, row increments.
    - After row=col=SPRITE_SIZE-1, go to DRAIN.
  - DRAIN (1 cycle):
    - Emits the screen stage for the last pixel.
    - Pulses o_blit_done.
    - Goes to LOAD if the FIFO is non-empty, else IDLE.
- Pipeline alignment:
  - The pixel whose o_address_s is issued in cycle N has o_address_screen = (y+row)*SCREEN_WIDTH + (x+col) in cycle N+1.
  - Its o_is_layer_drawing is asserted in cycle N+1 only when visible.
  - This matches the one-cycle sprite ROM read latency.
- Clipping:
  - A pixel is visible iff x+col < SCREEN_WIDTH and y+row < SCREEN_HEIGHT.
  - Compute the sums in 11 bits so that x up to 1023 cannot wrap.
  - Invisible pixels still consume their cycle, with o_is_layer_drawing=0 and o_address_screen held at 0.
  - A fully off-screen blit still takes SPRITE_SIZE^2+2 cycles and still pulses done.
- Latency:
  - Push to first o_address_s is at least 2 cycles (IDLE→LOAD→RUN).
  - Back-to-back blits cost SPRITE_SIZE^2+2 cycles each.
- i_frame_clear:
  - On the next edge: FIFO emptied, FSM IDLE, o_is_layer_drawing=0, no o_blit_done for the aborted blit.
  - A push in the same cycle is dropped.
  - Takes priority over every other event.
- Arithmetic:
  - Screen address multiply by the SCREEN_WIDTH constant (shift-add acceptable), truncated to VRAM_A_WIDTH.
  - The max visible address is 57599, so no truncation occurs in range.
- o_busy = (state != IDLE) || FIFO non-empty.

Decomposition:
- Shared package holds:
  - screen/sprite geometry constants;
  - sprite index localparams (background, ball, fail-hole, win-hole, holder, select, mode, pause);
  - FSM state encoding.
- One natural sub-module, cmd_fifo:
  - synchronous FIFO, width SPRITE_IDX_WIDTH+20, depth CMD_FIFO_DEPTH;
  - push/pop/flush, full/empty flags, async active-low reset.

Test Plan:
1. Reset mid-RUN (rst low 1 cycle at pixel 100) -> all outputs 0 immediately, o_cmd_ready=1, no o_blit_done afterward.
2. Push {index=1, x=10, y=20} -> first o_address_s=1024 two cycles later; next cycle o_address_screen=6410 with drawing=1. Last pixel: o_address_s=2047, then screen address 51*320+41=16361 together with the o_blit_done pulse, 1026 cycles after LOAD.
3. Push {index=2, x=300, y=170} -> drawing asserted only for col<20 and row<10, i.e. 200 pulses. Max address 179*320+319=57599.
4. Push {x=400, y=0} -> zero drawing pulses, o_blit_done still after 1026 cycles, o_busy falls next cycle.
5. Push 5 commands back-to-back while idle -> ready low after the 4th is held (1st popped, 4 queued). All blits execute in order, each 1026 cycles apart, with 5 o_blit_done pulses.
6. i_frame_clear during the 2nd of 3 queued blits, with a simultaneous push -> next cycle IDLE, o_busy=0, drawing=0, no further done pulses, pushed command lost.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Geometry, sprite ids, command format and FSM encoding shared by the
// sprite blitter and its command FIFO.
package sprite_blitter_pkg;

  localparam int SCREEN_WIDTH      = 320;
  localparam int SCREEN_HEIGHT     = 180;
  localparam int SPRITE_SIZE       = 32;
  localparam int SPRITE_LOG2       = $clog2(SPRITE_SIZE);
  localparam int SPRITE_IDX_WIDTH  = 3;
  localparam int VRAM_A_WIDTH      = 16;
  localparam int SPRITEBUF_A_WIDTH = 15;
  localparam int CMD_FIFO_DEPTH    = 4;
  localparam int COORD_WIDTH       = 10;
  localparam int CMD_WIDTH         = SPRITE_IDX_WIDTH + 2 * COORD_WIDTH;

  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_BACKGROUND = 3'd0;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_BALL       = 3'd1;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_FAIL_HOLE  = 3'd2;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_WIN_HOLE   = 3'd3;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_HOLDER     = 3'd4;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_SELECT     = 3'd5;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_MODE       = 3'd6;
  localparam logic [SPRITE_IDX_WIDTH-1:0] SPR_PAUSE      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [SPRITE_IDX_WIDTH-1:0] index;
    logic [COORD_WIDTH-1:0]      x;
    logic [COORD_WIDTH-1:0]      y;
  } blit_cmd_t;

endpackage

// File: rtl/sprite_blitter_cmd_fifo.sv
// Small synchronous command FIFO with flush; flush wins over push and pop.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;
  assign o_rdata = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= i_wdata;
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a queued 32x32 sprite, issuing ROM read addresses and,
// one cycle later, the clipped frame-buffer write address of the same pixel.
//
// state | meaning
// IDLE  | waiting for a queued command
// LOAD  | pop head, latch index/x/y, reset row/col
// RUN   | one sprite pixel per cycle on o_address_s
// DRAIN | screen stage of the last pixel, o_blit_done pulse
import sprite_blitter_pkg::*;

module sprite_blitter (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         i_frame_clear,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [SPRITE_IDX_WIDTH-1:0]  i_cmd_index,
  input  logic [COORD_WIDTH-1:0]       i_cmd_x,
  input  logic [COORD_WIDTH-1:0]       i_cmd_y,
  output logic [SPRITEBUF_A_WIDTH-1:0] o_address_s,
  output logic [VRAM_A_WIDTH-1:0]      o_address_screen,
  output logic                         o_is_layer_drawing,
  output logic                         o_busy,
  output logic                         o_blit_done
);

  localparam logic [SPRITE_LOG2-1:0] POS_MAX = SPRITE_LOG2'(SPRITE_SIZE - 1);

  state_t                  state_q, state_d;
  blit_cmd_t               cur_q, cur_d;
  blit_cmd_t               fifo_head;
  logic [SPRITE_LOG2-1:0]  row_q, row_d, col_q, col_d;
  logic [VRAM_A_WIDTH-1:0] scr_q, scr_d;
  logic                    draw_q, draw_d;
  logic                    fifo_pop, fifo_full, fifo_empty;

  logic [COORD_WIDTH:0]    pix_x, pix_y;
  logic                    pix_visible;
  logic [VRAM_A_WIDTH-1:0] pix_addr;

  cmd_fifo #(
    .WIDTH(CMD_WIDTH),
    .DEPTH(CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .CLK     (CLK),
    .rst     (rst),
    .i_flush (i_frame_clear),
    .i_push  (i_cmd_valid),
    .i_pop   (fifo_pop),
    .i_wdata ({i_cmd_index, i_cmd_x, i_cmd_y}),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // 11-bit sums so an x or y near 1023 cannot wrap back on-screen.
  assign pix_x = {1'b0, cur_q.x} + {{(COORD_WIDTH + 1 - SPRITE_LOG2){1'b0}}, col_q};
  assign pix_y = {1'b0, cur_q.y} + {{(COORD_WIDTH + 1 - SPRITE_LOG2){1'b0}}, row_q};
  assign pix_visible = (pix_x < (COORD_WIDTH+1)'(SCREEN_WIDTH)) &&
                       (pix_y < (COORD_WIDTH+1)'(SCREEN_HEIGHT));
  assign pix_addr = VRAM_A_WIDTH'(pix_y) * VRAM_A_WIDTH'(SCREEN_WIDTH) + VRAM_A_WIDTH'(pix_x);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    row_d    = row_q;
    col_d    = col_q;
    draw_d   = 1'b0;
    scr_d    = '0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        cur_d    = fifo_head;
        row_d    = '0;
        col_d    = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        draw_d = pix_visible;
        scr_d  = pix_visible ? pix_addr : '0;
        col_d  = col_q + 1'b1;
        if (col_q == POS_MAX) begin
          row_d = row_q + 1'b1;
          if (row_q == POS_MAX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_frame_clear) begin
      state_d  = ST_IDLE;
      fifo_pop = 1'b0;
      draw_d   = 1'b0;
      scr_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      scr_q   <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      row_q   <= row_d;
      col_q   <= col_d;
      scr_q   <= scr_d;
      draw_q  <= draw_d;
    end
  end

  assign o_cmd_ready        = !fifo_full;
  assign o_address_s        = (state_q == ST_RUN) ?
                              SPRITEBUF_A_WIDTH'({cur_q.index, row_q, col_q}) : '0;
  assign o_address_screen   = scr_q;
  assign o_is_layer_drawing = draw_q;
  assign o_blit_done        = (state_q == ST_DRAIN);
  assign o_busy             = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: cycle-accurate timeline model of queued blits,
// a table of known geometry cases, random commands and reset/clear sequences.
`timescale 1ns/1ps
module tb_sprite_blitter;
  import sprite_blitter_pkg::*;

  localparam int NPIX     = SPRITE_SIZE * SPRITE_SIZE;
  localparam int BLIT_CYC = NPIX + 2;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        i_frame_clear = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [2:0]  i_cmd_index = '0;
  logic [9:0]  i_cmd_x = '0;
  logic [9:0]  i_cmd_y = '0;
  logic        o_cmd_ready;
  logic [14:0] o_address_s;
  logic [15:0] o_address_screen;
  logic        o_is_layer_drawing;
  logic        o_busy;
  logic        o_blit_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sprite_blitter dut (
    .CLK                (CLK),
    .rst                (rst),
    .i_frame_clear      (i_frame_clear),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_index        (i_cmd_index),
    .i_cmd_x            (i_cmd_x),
    .i_cmd_y            (i_cmd_y),
    .o_address_s        (o_address_s),
    .o_address_screen   (o_address_screen),
    .o_is_layer_drawing (o_is_layer_drawing),
    .o_busy             (o_busy),
    .o_blit_done        (o_blit_done)
  );

  typedef struct { int idx; int x; int y; } cmd_t;
  typedef struct { cmd_t c; int draws; int max_scr; } vec_t;

  cmd_t cmds[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cycles(input string name, input int mism, input string first);
    n_checks++;
    if (mism != 0) begin
      n_errors++;
      $display("FAIL %s: %0d mismatching cycles, expected 0 (first %s)", name, mism, first);
    end
  endtask

  task automatic drive(input bit en, input int i);
    if (en && i < 8) begin
      i_cmd_valid = 1'b1;
      i_cmd_index = 3'(cmds[i].idx);
      i_cmd_x     = 10'(cmds[i].x);
      i_cmd_y     = 10'(cmds[i].y);
    end else begin
      i_cmd_valid = 1'b0;
    end
  endtask

  function automatic int clip_len(input int start, input int limit);
    if (start >= limit) return 0;
    if (limit - start < SPRITE_SIZE) return limit - start;
    return SPRITE_SIZE;
  endfunction

  // Pushes cmds[0..n_att-1] on consecutive edges (edge 0 first) and compares
  // every cycle t = 0..last_t against the expected blit timeline. Blit k is
  // popped on edge 2+1026k; its pixel p is on o_address_s at cycle 2+1026k+p
  // and on the screen port one cycle later; done at cycle 1026+1026k.
  task automatic watch(input int n_att, input int last_t, output int n_draw,
                       output int max_scr, output int done_t, output int n_done);
    int occ, n_acc, u, p, xs, ys;
    int e_s, e_scr, e_draw, e_done, e_busy, e_ready;
    bit push, pop, active;
    int m_s, m_scr, m_draw, m_done, m_busy, m_ready;
    string f_s, f_scr, f_draw, f_done, f_busy, f_ready;
    occ = 0; n_acc = 0;
    m_s = 0; m_scr = 0; m_draw = 0; m_done = 0; m_busy = 0; m_ready = 0;
    f_s = ""; f_scr = ""; f_draw = ""; f_done = ""; f_busy = ""; f_ready = "";
    n_draw = 0; max_scr = 0; done_t = -1; n_done = 0;
    @(negedge CLK);
    drive(n_att > 0, 0);
    for (int t = 0; t <= last_t; t++) begin
      @(negedge CLK);
      push = (t < n_att) && (occ < CMD_FIFO_DEPTH);
      pop = 1'b0;
      for (int k = 0; k < n_acc; k++) if (t == 2 + BLIT_CYC * k) pop = 1'b1;
      if (push) n_acc++;
      occ = occ + int'(push) - int'(pop);

      e_s = 0; e_scr = 0; e_draw = 0; e_done = 0; active = 1'b0;
      for (int k = 0; k < n_acc; k++) begin
        u = t - BLIT_CYC * k;
        if (u >= 1 && u <= NPIX + 2) active = 1'b1;
        if (u >= 2 && u <= NPIX + 1) e_s = cmds[k].idx * NPIX + (u - 2);
        if (u >= 3 && u <= NPIX + 2) begin
          p  = u - 3;
          xs = cmds[k].x + p % SPRITE_SIZE;
          ys = cmds[k].y + p / SPRITE_SIZE;
          if (xs < SCREEN_WIDTH && ys < SCREEN_HEIGHT) begin
            e_draw = 1;
            e_scr  = ys * SCREEN_WIDTH + xs;
          end
        end
        if (u == NPIX + 2) e_done = 1;
      end
      e_busy  = (active || occ > 0) ? 1 : 0;
      e_ready = (occ < CMD_FIFO_DEPTH) ? 1 : 0;

      if (int'(o_address_s) != e_s) begin
        if (m_s == 0) f_s = $sformatf("t=%0d got %0d exp %0d", t, o_address_s, e_s);
        m_s++;
      end
      if (int'(o_address_screen) != e_scr) begin
        if (m_scr == 0) f_scr = $sformatf("t=%0d got %0d exp %0d", t, o_address_screen, e_scr);
        m_scr++;
      end
      if (int'(o_is_layer_drawing) != e_draw) begin
        if (m_draw == 0) f_draw = $sformatf("t=%0d got %0d exp %0d", t, o_is_layer_drawing, e_draw);
        m_draw++;
      end
      if (int'(o_blit_done) != e_done) begin
        if (m_done == 0) f_done = $sformatf("t=%0d got %0d exp %0d", t, o_blit_done, e_done);
        m_done++;
      end
      if (int'(o_busy) != e_busy) begin
        if (m_busy == 0) f_busy = $sformatf("t=%0d got %0d exp %0d", t, o_busy, e_busy);
        m_busy++;
      end
      if (int'(o_cmd_ready) != e_ready) begin
        if (m_ready == 0) f_ready = $sformatf("t=%0d got %0d exp %0d", t, o_cmd_ready, e_ready);
        m_ready++;
      end

      if (o_is_layer_drawing) begin
        n_draw++;
        if (int'(o_address_screen) > max_scr) max_scr = int'(o_address_screen);
      end
      if (o_blit_done) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      drive((t + 1) < n_att, t + 1);
    end
    chk_cycles("address_s", m_s, f_s);
    chk_cycles("address_screen", m_scr, f_scr);
    chk_cycles("is_layer_drawing", m_draw, f_draw);
    chk_cycles("blit_done", m_done, f_done);
    chk_cycles("busy", m_busy, f_busy);
    chk_cycles("cmd_ready", m_ready, f_ready);
  endtask

  task automatic idle_watch(input int cyc, output int nd, output int nb,
                            output int ndr, output int ns);
    nd = 0; nb = 0; ndr = 0; ns = 0;
    for (int t = 0; t < cyc; t++) begin
      @(negedge CLK);
      if (o_blit_done) nd++;
      if (o_busy) nb++;
      if (o_is_layer_drawing) ndr++;
      if (o_address_s != '0 || o_address_screen != '0) ns++;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int nd, mx, dt, ndn, nb, ndr, ns, wv, hv;

    vecs[0] = '{c: '{idx: 1, x: 10,   y: 20},   draws: 1024, max_scr: 16361};
    vecs[1] = '{c: '{idx: 2, x: 300,  y: 170},  draws: 200,  max_scr: 57599};
    vecs[2] = '{c: '{idx: 0, x: 400,  y: 0},    draws: 0,    max_scr: 0};
    vecs[3] = '{c: '{idx: 7, x: 0,    y: 0},    draws: 1024, max_scr: 9951};
    vecs[4] = '{c: '{idx: 3, x: 319,  y: 179},  draws: 1,    max_scr: 57599};
    vecs[5] = '{c: '{idx: 5, x: 1023, y: 1023}, draws: 0,    max_scr: 0};

    // Reset state
    #1;
    chk("reset_cmd_ready", int'(o_cmd_ready), 1);
    chk("reset_outputs_nonzero",
        int'(o_address_s != '0) + int'(o_address_screen != '0) + int'(o_is_layer_drawing) +
        int'(o_busy) + int'(o_blit_done), 0);
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    repeat (2) @(negedge CLK);

    // Table of geometry cases
    foreach (vecs[i]) begin
      cmds[0] = vecs[i].c;
      watch(1, BLIT_CYC + 2, nd, mx, dt, ndn);
      chk($sformatf("vec%0d_draws", i), nd, vecs[i].draws);
      chk($sformatf("vec%0d_max_scr", i), mx, vecs[i].max_scr);
      chk($sformatf("vec%0d_done_t", i), dt, 1026);
      chk($sformatf("vec%0d_done_cnt", i), ndn, 1);
    end

    // Random commands
    for (int r = 0; r < 8; r++) begin
      cmds[0] = '{idx: int'($urandom_range(0, 7)), x: int'($urandom_range(0, 400)),
                  y: int'($urandom_range(0, 220))};
      watch(1, BLIT_CYC + 2, nd, mx, dt, ndn);
      wv = clip_len(cmds[0].x, SCREEN_WIDTH);
      hv = clip_len(cmds[0].y, SCREEN_HEIGHT);
      chk($sformatf("rand%0d_draws", r), nd, wv * hv);
      chk($sformatf("rand%0d_done_cnt", r), ndn, 1);
    end

    // Six push attempts back-to-back: five accepted, sixth dropped on full
    for (int i = 0; i < 6; i++)
      cmds[i] = '{idx: i, x: 40 * i, y: 25 * i};
    watch(6, 5 * BLIT_CYC + 2, nd, mx, dt, ndn);
    chk("b2b_done_cnt", ndn, 5);
    chk("b2b_first_done_t", dt, 1026);

    // Frame clear mid second blit with a simultaneous push
    for (int i = 0; i < 3; i++)
      cmds[i] = '{idx: 6 - i, x: 100 + i, y: 50 + i};
    watch(3, BLIT_CYC + 500, nd, mx, dt, ndn);
    chk("fc_done_before_clear", ndn, 1);
    cmds[3] = '{idx: 4, x: 5, y: 5};
    i_frame_clear = 1'b1;
    drive(1'b1, 3);
    @(negedge CLK);
    i_frame_clear = 1'b0;
    i_cmd_valid   = 1'b0;
    chk("fc_busy", int'(o_busy), 0);
    chk("fc_drawing", int'(o_is_layer_drawing), 0);
    chk("fc_cmd_ready", int'(o_cmd_ready), 1);
    idle_watch(1100, nd, nb, ndr, ns);
    chk("fc_late_done", nd, 0);
    chk("fc_late_busy", nb, 0);
    chk("fc_late_draw", ndr, 0);

    // Asynchronous reset at pixel 100 of a RUN
    cmds[0] = '{idx: 1, x: 10, y: 20};
    watch(1, 102, nd, mx, dt, ndn);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", int'(o_cmd_ready), 1);
    chk("rst_address_s", int'(o_address_s), 0);
    chk("rst_outputs_nonzero",
        int'(o_address_screen != '0) + int'(o_is_layer_drawing) + int'(o_busy) +
        int'(o_blit_done), 0);
    @(negedge CLK);
    rst = 1'b1;
    idle_watch(1100, nd, nb, ndr, ns);
    chk("rst_late_done", nd, 0);
    chk("rst_late_busy", nb, 0);
    chk("rst_late_addr", ns, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
